// File: rtl/bpu_update_arb.sv
// Arbitrates decode-stage and execute-stage branch predictor updates onto one write port.
// Each stage has its own small FIFO, and execute-stage mispredictions normally win.
module bpu_update_arb #(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 ds_valid,
    input  logic [31:0]                ds_pc0,
    input  logic [31:0]                ds_pc1,
    input  logic [1:0]                 ds_may_jump,
    output logic                       ds_ready,
    input  logic [1:0]                 es_valid,
    input  logic [31:0]                es_pc0,
    input  logic [31:0]                es_pc1,
    input  logic [1:0]                 es_taken,
    input  logic [1:0]                 es_mispred,
    input  logic [31:0]                es_target0,
    input  logic [31:0]                es_target1,
    output logic                       es_ready,
    input  logic                       flush,
    output logic                       upd_valid,
    input  logic                       upd_ready,
    output logic                       upd_src,
    output logic [31:0]                upd_pc,
    output logic [31:0]                upd_target,
    output logic                       upd_taken,
    output logic [$clog2(DEPTH):0]     occ_ds,
    output logic [$clog2(DEPTH):0]     occ_es
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic [31:0]   ds_pc_mem [DEPTH];
    logic          ds_mj_mem [DEPTH];
    logic [31:0]   es_pc_mem [DEPTH];
    logic          es_tk_mem [DEPTH];
    logic [31:0]   es_tg_mem [DEPTH];

    logic [AW-1:0] ds_wptr, ds_rptr, es_wptr, es_rptr;
    logic [SW-1:0] starve_cnt;
    logic          lock_q, lock_es_q;

    logic [1:0]    ds_acc, es_acc;
    logic [CW-1:0] ds_push_n, es_push_n;
    logic [AW-1:0] ds_w1, es_w1;
    logic          ds_ne, es_ne, arb_es, sel_es, fire, ds_pop, es_pop;

    // Ready is derived from registered occupancy only so it never depends on same-cycle valids.
    assign ds_ready  = (occ_ds <= CW'(DEPTH - 2));
    assign es_ready  = (occ_es <= CW'(DEPTH - 2));
    assign ds_acc    = (ds_ready && !flush) ? ds_valid : 2'b00;
    assign es_acc    = es_ready ? (es_valid & es_mispred) : 2'b00;
    assign ds_push_n = CW'(ds_acc[0]) + CW'(ds_acc[1]);
    assign es_push_n = CW'(es_acc[0]) + CW'(es_acc[1]);
    assign ds_w1     = ds_wptr + AW'(ds_acc[0]);
    assign es_w1     = es_wptr + AW'(es_acc[0]);

    assign ds_ne     = (occ_ds != '0);
    assign es_ne     = (occ_es != '0);
    assign arb_es    = es_ne && (!ds_ne || (starve_cnt != SW'(STARVE_LIM)));
    // A stalled grant stays on its source until the predictor takes it.
    assign sel_es    = (lock_q && (lock_es_q ? es_ne : ds_ne)) ? lock_es_q : arb_es;
    assign upd_valid = ds_ne || es_ne;
    assign fire      = upd_valid && upd_ready;
    assign ds_pop    = fire && !sel_es;
    assign es_pop    = fire && sel_es;

    always_comb begin
        upd_src    = 1'b0;
        upd_pc     = '0;
        upd_target = '0;
        upd_taken  = 1'b0;
        if (upd_valid) begin
            if (sel_es) begin
                upd_src    = 1'b1;
                upd_pc     = es_pc_mem[es_rptr];
                upd_target = es_tg_mem[es_rptr];
                upd_taken  = es_tk_mem[es_rptr];
            end else begin
                upd_pc     = ds_pc_mem[ds_rptr];
                upd_taken  = ds_mj_mem[ds_rptr];
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (ds_acc[0]) begin
            ds_pc_mem[ds_wptr] <= ds_pc0;
            ds_mj_mem[ds_wptr] <= ds_may_jump[0];
        end
        if (ds_acc[1]) begin
            ds_pc_mem[ds_w1] <= ds_pc1;
            ds_mj_mem[ds_w1] <= ds_may_jump[1];
        end
        if (es_acc[0]) begin
            es_pc_mem[es_wptr] <= es_pc0;
            es_tk_mem[es_wptr] <= es_taken[0];
            es_tg_mem[es_wptr] <= es_target0;
        end
        if (es_acc[1]) begin
            es_pc_mem[es_w1] <= es_pc1;
            es_tk_mem[es_w1] <= es_taken[1];
            es_tg_mem[es_w1] <= es_target1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_wptr    <= '0;
            ds_rptr    <= '0;
            occ_ds     <= '0;
            es_wptr    <= '0;
            es_rptr    <= '0;
            occ_es     <= '0;
            starve_cnt <= '0;
            lock_q     <= 1'b0;
            lock_es_q  <= 1'b0;
        end else begin
            es_wptr <= es_wptr + AW'(es_push_n);
            es_rptr <= es_rptr + AW'(es_pop);
            occ_es  <= occ_es + es_push_n - CW'(es_pop);

            // Flush empties the DS queue even if its head was granted this cycle.
            if (flush) begin
                ds_wptr <= '0;
                ds_rptr <= '0;
                occ_ds  <= '0;
            end else begin
                ds_wptr <= ds_wptr + AW'(ds_push_n);
                ds_rptr <= ds_rptr + AW'(ds_pop);
                occ_ds  <= occ_ds + ds_push_n - CW'(ds_pop);
            end

            if (flush || ds_pop || !ds_ne)
                starve_cnt <= '0;
            else if (es_pop && (starve_cnt != SW'(STARVE_LIM)))
                starve_cnt <= starve_cnt + SW'(1);

            lock_q    <= !flush && upd_valid && !upd_ready;
            lock_es_q <= sel_es;
        end
    end
endmodule

// File: tb/tb_bpu_update_arb.sv
// Randomized bench for bpu_update_arb against a queue-based reference model,
// with directed scenarios for priority, starvation, full, filter/wrap, flush and reset.
module tb_bpu_update_arb;
    localparam int DEPTH      = 4;
    localparam int STARVE_LIM = 4;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    ds_valid, ds_may_jump;
    logic [31:0]   ds_pc0, ds_pc1;
    logic          ds_ready;
    logic [1:0]    es_valid, es_taken, es_mispred;
    logic [31:0]   es_pc0, es_pc1, es_target0, es_target1;
    logic          es_ready;
    logic          flush;
    logic          upd_valid, upd_ready, upd_src, upd_taken;
    logic [31:0]   upd_pc, upd_target;
    logic [CW-1:0] occ_ds, occ_es;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tg;
    } ent_t;

    ent_t mds[$];
    ent_t mes[$];
    int   mStarve = 0;
    bit   mLock   = 0;
    bit   mLockEs = 0;

    bpu_update_arb #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .reset(reset),
        .ds_valid(ds_valid), .ds_pc0(ds_pc0), .ds_pc1(ds_pc1),
        .ds_may_jump(ds_may_jump), .ds_ready(ds_ready),
        .es_valid(es_valid), .es_pc0(es_pc0), .es_pc1(es_pc1),
        .es_taken(es_taken), .es_mispred(es_mispred),
        .es_target0(es_target0), .es_target1(es_target1), .es_ready(es_ready),
        .flush(flush),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_src(upd_src),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .occ_ds(occ_ds), .occ_es(occ_es)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] dv, input logic [1:0] mj,
                                 input logic [1:0] ev, input logic [1:0] emp,
                                 input logic [1:0] etk, input logic fl, input logic rdy);
        ds_valid    = dv;
        ds_may_jump = mj;
        es_valid    = ev;
        es_mispred  = emp;
        es_taken    = etk;
        flush       = fl;
        upd_ready   = rdy;
    endtask

    // Arbitration rule: a held grant sticks, otherwise ES wins unless DS has waited STARVE_LIM grants.
    function automatic bit modelSelEs();
        if (mLock && (mLockEs ? (mes.size() != 0) : (mds.size() != 0)))
            return mLockEs;
        if (mes.size() != 0 && mds.size() != 0)
            return (mStarve != STARVE_LIM);
        return (mes.size() != 0);
    endfunction

    task automatic modelCompare();
        bit          v;
        bit          se;
        ent_t        h;
        logic [31:0] ePc, eTg;
        logic        eTk, eSrc;
        v    = (mds.size() != 0) || (mes.size() != 0);
        se   = modelSelEs();
        ePc  = '0; eTg = '0; eTk = 1'b0; eSrc = 1'b0;
        if (v) begin
            if (se) begin
                h = mes[0]; ePc = h.pc; eTg = h.tg; eTk = h.tk; eSrc = 1'b1;
            end else begin
                h = mds[0]; ePc = h.pc; eTk = h.tk;
            end
        end
        checkOutput("upd_valid", 32'(upd_valid), 32'(v));
        checkOutput("upd_src", 32'(upd_src), 32'(eSrc));
        checkOutput("upd_pc", upd_pc, ePc);
        checkOutput("upd_target", upd_target, eTg);
        checkOutput("upd_taken", 32'(upd_taken), 32'(eTk));
        checkOutput("occ_ds", 32'(occ_ds), 32'(mds.size()));
        checkOutput("occ_es", 32'(occ_es), 32'(mes.size()));
        checkOutput("ds_ready", 32'(ds_ready), 32'((DEPTH - mds.size()) >= 2));
        checkOutput("es_ready", 32'(es_ready), 32'((DEPTH - mes.size()) >= 2));
    endtask

    task automatic modelUpdate();
        bit   v, se, fire, dsPop, esPop, dsHad, dsr, esr;
        ent_t e;
        if (reset) begin
            mds.delete(); mes.delete();
            mStarve = 0; mLock = 0; mLockEs = 0;
            return;
        end
        v     = (mds.size() != 0) || (mes.size() != 0);
        se    = modelSelEs();
        fire  = v && upd_ready;
        dsPop = fire && !se;
        esPop = fire && se;
        dsHad = (mds.size() != 0);
        dsr   = (DEPTH - mds.size()) >= 2;
        esr   = (DEPTH - mes.size()) >= 2;
        if (dsPop) void'(mds.pop_front());
        if (esPop) void'(mes.pop_front());
        if (flush || dsPop || !dsHad) mStarve = 0;
        else if (esPop && mStarve < STARVE_LIM) mStarve++;
        if (esr) begin
            for (int i = 0; i < 2; i++) begin
                if (es_valid[i] && es_mispred[i]) begin
                    e.pc = (i == 0) ? es_pc0 : es_pc1;
                    e.tk = es_taken[i];
                    e.tg = (i == 0) ? es_target0 : es_target1;
                    mes.push_back(e);
                end
            end
        end
        if (flush) mds.delete();
        else if (dsr) begin
            for (int i = 0; i < 2; i++) begin
                if (ds_valid[i]) begin
                    e.pc = (i == 0) ? ds_pc0 : ds_pc1;
                    e.tk = ds_may_jump[i];
                    e.tg = '0;
                    mds.push_back(e);
                end
            end
        end
        mLock   = !flush && v && !upd_ready;
        mLockEs = se;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        modelCompare();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) stepCycle();
    endtask

    initial begin
        reset = 1'b1;
        ds_pc0 = '0; ds_pc1 = '0; es_pc0 = '0; es_pc1 = '0;
        es_target0 = '0; es_target1 = '0;
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        stepCycle();
        stepCycle();
        reset = 1'b0;
        checkOutput("rst_upd_valid", 32'(upd_valid), 32'd0);
        checkOutput("rst_upd_pc", upd_pc, 32'd0);
        checkOutput("rst_occ_ds", 32'(occ_ds), 32'd0);
        checkOutput("rst_occ_es", 32'(occ_es), 32'd0);
        checkOutput("rst_ds_ready", 32'(ds_ready), 32'd1);
        checkOutput("rst_es_ready", 32'(es_ready), 32'd1);

        // ES beats DS when both arrive together.
        es_pc0 = 32'h1000; es_target0 = 32'h2000; ds_pc0 = 32'h3000;
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        checkOutput("prio_src0", 32'(upd_src), 32'd1);
        checkOutput("prio_pc0", upd_pc, 32'h1000);
        checkOutput("prio_tgt0", upd_target, 32'h2000);
        stepCycle();
        checkOutput("prio_src1", 32'(upd_src), 32'd0);
        checkOutput("prio_pc1", upd_pc, 32'h3000);
        checkOutput("prio_tgt1", upd_target, 32'h0);
        drain();

        // One waiting DS entry under a continuous ES stream gets the fifth grant.
        ds_pc0 = 32'h4000;
        for (int i = 0; i < 6; i++) begin
            es_pc0 = 32'h5000 + 32'(i * 4);
            if (i == 0) applyStimulus(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1);
            else        applyStimulus(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1);
            stepCycle();
            checkOutput("starve_src", 32'(upd_src), (i == 4) ? 32'd0 : 32'd1);
        end
        drain();

        // Full ES queue drops a further request.
        es_pc0 = 32'h6000; es_pc1 = 32'h6004;
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
        stepCycle();
        checkOutput("full_es_ready", 32'(es_ready), 32'd0);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
        stepCycle();
        checkOutput("full_occ_es", 32'(occ_es), 32'd3);
        drain();

        // Only mispredicted slot0 entries survive, across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            es_pc0 = 32'h7000 + 32'(i * 8); es_pc1 = 32'h7004 + 32'(i * 8);
            applyStimulus(2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0, 1'b1);
            stepCycle();
            checkOutput("filter_pc", upd_pc, 32'h7000 + 32'(i * 8));
        end
        drain();

        // Flush empties DS while the ES entry survives.
        ds_pc0 = 32'h8000; ds_pc1 = 32'h8004; es_pc0 = 32'h9000;
        applyStimulus(2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        stepCycle();
        checkOutput("flush_pre_occ_ds", 32'(occ_ds), 32'd3);
        applyStimulus(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        stepCycle();
        checkOutput("flush_occ_ds", 32'(occ_ds), 32'd0);
        checkOutput("flush_occ_es", 32'(occ_es), 32'd1);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        checkOutput("flush_es_pc", upd_pc, 32'h9000);
        drain();

        // Backpressure holds the port, then reset clears everything.
        ds_pc0 = 32'hA000; es_pc0 = 32'hB000; es_target0 = 32'hC000;
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            ds_pc0 = 32'hA100 + 32'(i);
            applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
            stepCycle();
            checkOutput("bp_pc", upd_pc, 32'hB000);
        end
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("bp_rst_valid", 32'(upd_valid), 32'd0);
        checkOutput("bp_rst_occ_ds", 32'(occ_ds), 32'd0);
        checkOutput("bp_rst_occ_es", 32'(occ_es), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            ds_pc0 = $urandom; ds_pc1 = $urandom;
            es_pc0 = $urandom; es_pc1 = $urandom;
            es_target0 = $urandom; es_target1 = $urandom;
            applyStimulus(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7));
            reset = ($urandom_range(0, 127) == 0);
            stepCycle();
        end
        reset = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
